dmem_byte_arbiter: RTL

//  Shares the 256-byte, byte-wide data memory between two 64-bit requesters (port 0: core load/store,

---
 rtl/dmem_byte_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dmem_byte_arbiter.sv
// Two-port round-robin arbiter that serialises 64-bit requests into
// little-endian byte cycles on a shared byte-wide data memory.
module dmem_byte_arbiter #(
  parameter int MEM_AW = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [63:0]       r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [63:0]       r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_last_grant;
  logic                r_owner;
  logic                r_we;
  logic [MEM_AW-1:0]   r_base;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rbuf;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_grant;
  logic                w_last_byte;
  logic                w_in_xfer;
  logic [MEM_AW-1:0]   w_byte_addr;
  logic [DATA_W-1:0]   w_rbuf_next;
  logic                w_unused_addr_bits;

  // Only the low MEM_AW address bits select a byte; the rest are ignored.
  assign w_unused_addr_bits = ^{r0_addr[63:MEM_AW], r1_addr[63:MEM_AW]};

  // On a tie the port that did not win last time is granted.
  assign w_grant     = (r0_valid && r1_valid) ? ~r_last_grant : r1_valid;
  assign w_last_byte = (r_cnt == CW'(NB - 1));
  assign w_in_xfer   = (r_state == S_XFER);
  assign w_byte_addr = r_base + MEM_AW'(r_cnt);

  // Read buffer with the byte of the current cycle replaced by mem_rdata.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_rbyte
      assign w_rbuf_next[8*gi +: 8] = (r_cnt == CW'(gi)) ? mem_rdata : r_rbuf[8*gi +: 8];
    end
  endgenerate

  // Memory strobes and ready pulses are decoded from registered state only.
  assign mem_addr  = w_in_xfer ? w_byte_addr : '0;
  assign mem_wdata = (w_in_xfer && r_we) ? r_wdata[8*r_cnt +: 8] : 8'h00;
  assign mem_we    = w_in_xfer && r_we;
  assign mem_re    = w_in_xfer && !r_we;
  assign r0_ready  = (r_state == S_DONE) && !r_owner;
  assign r1_ready  = (r_state == S_DONE) && r_owner;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;

  // Arbitration, byte sequencing and read-data assembly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_base       <= '0;
      r_wdata      <= '0;
      r_rbuf       <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r0_valid || r1_valid) begin
            r_last_grant <= w_grant;
            r_owner      <= w_grant;
            r_cnt        <= '0;
            r_state      <= S_XFER;
            if (w_grant) begin
              r_we    <= r1_we;
              r_base  <= r1_addr[MEM_AW-1:0];
              r_wdata <= r1_wdata;
            end else begin
              r_we    <= r0_we;
              r_base  <= r0_addr[MEM_AW-1:0];
              r_wdata <= r0_wdata;
            end
          end
        end
        S_XFER: begin
          if (!r_we) begin
            r_rbuf <= w_rbuf_next;
          end
          if (w_last_byte) begin
            // Publish read data so it is valid together with the ready pulse.
            if (!r_we) begin
              if (r_owner) begin
                r_rdata1 <= w_rbuf_next;
              end else begin
                r_rdata0 <= w_rbuf_next;
              end
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
